// File: rtl/serial_subtractor64_if.sv
// rtl/serial_subtractor64_if.sv - start/busy/done handshake and operand/result bundle for serial_subtractor64
interface serial_subtractor64_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start, x, y, borrow_in,
    input  busy, done, diff, borrow_out, zero, overflow
  );

  modport slave (
    input  start, x, y, borrow_in,
    output busy, done, diff, borrow_out, zero, overflow
  );
endinterface

// File: rtl/serial_subtractor64.sv
// rtl/serial_subtractor64.sv - multi-cycle subtractor computing x - y - borrow_in one slice per clock
module serial_subtractor64 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor64_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   partial;
  logic [KW-1:0]      k;
  logic               b;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_out_q;
  logic               zero_q;
  logic               overflow_q;

  logic [SLICE:0]     slice_sum;
  logic               slice_borrow;
  logic [WIDTH-1:0]   partial_nxt;

  // One slice of x + ~y + ~borrow; the full result including the current slice feeds the final load
  always_comb begin
    slice_sum    = {1'b0, x_q[k*SLICE +: SLICE]}
                 + {1'b0, ~y_q[k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, ~b};
    slice_borrow = ~slice_sum[SLICE];
    partial_nxt  = partial;
    partial_nxt[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  // Control FSM with operand capture, slice iteration and registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      partial      <= '0;
      k            <= '0;
      b            <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          partial <= partial_nxt;
          b       <= slice_borrow;
          if (k == K_LAST) begin
            state        <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            diff_q       <= partial_nxt;
            borrow_out_q <= slice_borrow;
            zero_q       <= (partial_nxt == '0);
            overflow_q   <= (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                            (partial_nxt[WIDTH-1] != x_q[WIDTH-1]);
          end else begin
            k <= k + 1'b1;
          end
        end
        // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise
        default: begin
          if (bus.start) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            x_q     <= bus.x;
            y_q     <= bus.y;
            b       <= bus.borrow_in;
            partial <= '0;
            k       <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_subtractor64.sv
// tb/tb_serial_subtractor64.sv - randomized and directed self-checking bench for serial_subtractor64
module tb_serial_subtractor64;
  localparam int W = 64;
  localparam int N = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  serial_subtractor64_if #(.WIDTH(W)) bus ();

  serial_subtractor64 #(.WIDTH(W), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: wide unsigned and signed arithmetic straight from the definition
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic z, output logic ov);
    logic [W:0] wide;
    logic signed [W+1:0] s;
    wide = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    d    = wide[W-1:0];
    bo   = wide[W];
    z    = (d == '0);
    s    = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y}) - $signed({{(W+1){1'b0}}, bin});
    ov   = (s != $signed({{2{d[W-1]}}, d}));
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drive a request at the current negedge; it is accepted on the next rising edge
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
    bus.start     = 1'b1;
    bus.x         = x;
    bus.y         = y;
    bus.borrow_in = bin;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.x         = rnd64();
    bus.y         = rnd64();
    bus.borrow_in = 1'($urandom);
  endtask

  // Follow one operation to done and compare everything against the model.
  // inject_at >= 0 pulses start with junk operands at that busy cycle.
  // hold_check verifies diff keeps hold_val while busy.
  task automatic wait_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic bin, input int inject_at,
                             input logic hold_check, input logic [W-1:0] hold_val);
    logic [W-1:0] ed;
    logic         ebo, ez, eov;
    int           lat, bcnt;
    logic         hold_ok;
    model(x, y, bin, ed, ebo, ez, eov);
    lat = -1;
    bcnt = 0;
    hold_ok = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.start) bus.start = 1'b0;
      if (bus.busy) begin
        bcnt++;
        if (hold_check && bus.diff !== hold_val) hold_ok = 1'b0;
      end
      if (bus.done) begin
        lat = j;
        break;
      end
      if (j == inject_at) begin
        bus.start     = 1'b1;
        bus.x         = rnd64();
        bus.y         = rnd64();
        bus.borrow_in = 1'($urandom);
      end
    end
    check({tag, " latency"}, W'(lat), W'(N));
    check({tag, " busy_cycles"}, W'(bcnt), W'(N));
    if (hold_check) check({tag, " diff_hold"}, W'(hold_ok), W'(1));
    check({tag, " diff"}, bus.diff, ed);
    check({tag, " borrow_out"}, W'(bus.borrow_out), W'(ebo));
    check({tag, " zero"}, W'(bus.zero), W'(ez));
    check({tag, " overflow"}, W'(bus.overflow), W'(eov));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
    @(negedge clk);
    issue(x, y, bin);
    wait_result(tag, x, y, bin, -1, 1'b0, '0);
  endtask

  initial begin
    logic [W-1:0] xa, ya, xb, yb, first_diff;
    logic         ba, bb;
    int           stray;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", W'(bus.busy), '0);
    check("reset done", W'(bus.done), '0);
    check("reset diff", bus.diff, '0);
    check("reset flags", W'({bus.borrow_out, bus.zero, bus.overflow}), '0);
    rst_n = 1'b1;

    run_op("basic", 64'd10, 64'd3, 1'b0);
    run_op("underflow", 64'd0, 64'd1, 1'b0);
    run_op("ripple4", 64'h10000, 64'd1, 1'b0);
    run_op("sovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    run_op("zero", 64'h1234, 64'h1234, 1'b0);
    run_op("zero_bin", 64'h1234, 64'h1234, 1'b1);
    run_op("sovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("max_min", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    for (int i = 0; i < 24; i++) begin
      xa = rnd64();
      ya = (i % 4 == 0) ? xa : rnd64();
      ba = 1'($urandom);
      run_op("random", xa, ya, ba);
    end

    // start pulse during busy must be ignored
    xa = rnd64(); ya = rnd64(); ba = 1'($urandom);
    @(negedge clk);
    issue(xa, ya, ba);
    wait_result("ignore_start", xa, ya, ba, 4, 1'b0, '0);

    // back-to-back: start held in the done cycle, diff holds through second busy
    xa = rnd64(); ya = rnd64(); ba = 1'($urandom);
    xb = rnd64(); yb = rnd64(); bb = 1'($urandom);
    @(negedge clk);
    issue(xa, ya, ba);
    wait_result("b2b first", xa, ya, ba, -1, 1'b0, '0);
    first_diff = bus.diff;
    issue(xb, yb, bb);
    check("b2b busy_immediate", W'(bus.busy), W'(1));
    wait_result("b2b second", xb, yb, bb, -1, 1'b1, first_diff);

    // reset in the middle of an operation whose predecessor left nonzero flags
    run_op("pre_reset", 64'h1234, 64'h1234, 1'b1);
    @(negedge clk);
    issue(rnd64(), rnd64(), 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", W'(bus.busy), '0);
    check("midreset done", W'(bus.done), '0);
    check("midreset diff", bus.diff, '0);
    check("midreset flags", W'({bus.borrow_out, bus.zero, bus.overflow}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    check("postreset no_activity", W'(stray), '0);
    run_op("postreset op", 64'd100, 64'd58, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
